// File: rtl/sentinel_status_if.sv
// Bundles the sentinel's input requests and encoded status outputs.
// The master drives the raw inputs (veto, temperature, heartbeat). The
// slave (the encoder) returns the status code, the change pulse and the
// cause flags.
interface sentinel_status_if;
  logic       veto_req;
  logic [7:0] temp_in;
  logic       temp_valid;
  logic       ai_heartbeat;
  logic [1:0] status_code_out;
  logic       status_changed;
  logic [2:0] cause_mask;

  modport master (
    output veto_req, temp_in, temp_valid, ai_heartbeat,
    input  status_code_out, status_changed, cause_mask
  );

  modport slave (
    input  veto_req, temp_in, temp_valid, ai_heartbeat,
    output status_code_out, status_changed, cause_mask
  );
endinterface

// File: rtl/sentinel_status_encoder.sv
// Sentinel status encoder.
// Condenses three fault sources into one 2-bit severity code:
//  - a debounced operator veto,
//  - a thermal flag with hysteresis,
//  - an AI heartbeat watchdog.
// Escalation to a higher severity takes effect immediately. De-escalation
// waits until a minimum hold time has expired, so the monitor never sees
// a short blip of a lower status.
module sentinel_status_encoder #(
  parameter int unsigned DEBOUNCE   = 4,
  parameter logic [7:0]  THERM_HI   = 8'd85,
  parameter logic [7:0]  THERM_LO   = 8'd75,
  parameter logic [15:0] HB_TIMEOUT = 16'd1000,
  parameter logic [7:0]  MIN_HOLD   = 8'd8
) (
  input logic              clk,
  input logic              rst_n,
  sentinel_status_if.slave bus
);

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_VETO    = 2'b01,
    ST_THERMAL = 2'b10,
    ST_AIFAULT = 2'b11
  } state_t;

  // The veto toggles on the DEBOUNCE-th differing edge. At that edge the
  // counter already holds DEBOUNCE-1.
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);

  logic        veto_active_reg;
  logic [3:0]  db_cnt_reg;
  logic        thermal_hot_reg;
  logic [15:0] hb_cnt_reg;
  logic        ai_fault;
  state_t      target;
  state_t      state_reg;
  state_t      state_next;
  logic [7:0]  hold_cnt_reg;
  logic [7:0]  hold_cnt_next;
  logic        status_changed_reg;

  // Veto debounce: count consecutive disagreeing edges, then toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      veto_active_reg <= 1'b0;
      db_cnt_reg      <= 4'd0;
    end else if (bus.veto_req != veto_active_reg) begin
      if (db_cnt_reg == DB_LAST) begin
        veto_active_reg <= ~veto_active_reg;
        db_cnt_reg      <= 4'd0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 4'd1;
      end
    end else begin
      db_cnt_reg <= 4'd0;
    end
  end

  // Thermal hysteresis: set at or above HI, clear at or below LO, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thermal_hot_reg <= 1'b0;
    end else if (bus.temp_valid) begin
      if (bus.temp_in >= THERM_HI) begin
        thermal_hot_reg <= 1'b1;
      end else if (bus.temp_in <= THERM_LO) begin
        thermal_hot_reg <= 1'b0;
      end
    end
  end

  // Heartbeat watchdog: a heartbeat clears the counter, otherwise it counts
  // up and saturates at the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_reg <= 16'd0;
    end else if (bus.ai_heartbeat) begin
      hb_cnt_reg <= 16'd0;
    end else if (hb_cnt_reg != HB_TIMEOUT) begin
      hb_cnt_reg <= hb_cnt_reg + 16'd1;
    end
  end

  assign ai_fault = (hb_cnt_reg == HB_TIMEOUT);

  // Priority encode the live flags into the desired severity.
  always_comb begin
    target = ST_OK;
    if (ai_fault) begin
      target = ST_AIFAULT;
    end else if (thermal_hot_reg) begin
      target = ST_THERMAL;
    end else if (veto_active_reg) begin
      target = ST_VETO;
    end
  end

  // Next status: escalate at once; de-escalate only after the hold expires.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    if (target > state_reg) begin
      state_next    = target;
      hold_cnt_next = MIN_HOLD;
    end else if (target < state_reg) begin
      if (hold_cnt_reg == 8'd0) begin
        state_next    = target;
        hold_cnt_next = (target == ST_OK) ? 8'd0 : MIN_HOLD;
      end else begin
        hold_cnt_next = hold_cnt_reg - 8'd1;
      end
    end else if (hold_cnt_reg != 8'd0) begin
      hold_cnt_next = hold_cnt_reg - 8'd1;
    end
  end

  // Status register, hold counter and registered change pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= ST_OK;
      hold_cnt_reg       <= 8'd0;
      status_changed_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      hold_cnt_reg       <= hold_cnt_next;
      status_changed_reg <= (state_next != state_reg);
    end
  end

  assign bus.status_code_out = state_reg;
  assign bus.status_changed  = status_changed_reg;
  assign bus.cause_mask      = {ai_fault, thermal_hot_reg, veto_active_reg};

endmodule

// File: tb/tb_sentinel_status_encoder.sv
// Bench for sentinel_status_encoder.
// A cycle model pushes the expected outputs to a queue whenever inputs are
// driven. The queue is popped and compared one time unit after each rising
// edge. A table of hand-derived checkpoints and a few directed sequences
// (watchdog, priority/hold, asynchronous reset) run on top of that.
module tb_sentinel_status_encoder;

  localparam int HB_TIMEOUT = 1000;
  localparam int MIN_HOLD   = 8;
  localparam int DEBOUNCE   = 4;
  localparam int THERM_HI   = 85;
  localparam int THERM_LO   = 75;

  typedef struct {
    logic [1:0] status;
    logic       changed;
    logic [2:0] mask;
  } exp_t;

  typedef struct {
    logic       veto;
    logic [7:0] temp;
    logic       tvalid;
    int         cycles;
    logic [1:0] exp_status;
    logic [2:0] exp_mask;
  } vec_t;

  logic clk;
  logic rst_n;
  sentinel_status_if bus_if ();

  sentinel_status_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  int   hb_phase = 0;
  exp_t sb_q[$];
  vec_t vecs[15];

  // Reference model state
  int m_veto, m_dbc, m_hot, m_hb, m_st, m_hold;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_veto = 0; m_dbc = 0; m_hot = 0; m_hb = 0; m_st = 0; m_hold = 0;
    sb_q.delete();
  endtask

  // Advance the model by one rising edge using the inputs about to be sampled.
  task automatic model_step(input bit v, input int t, input bit tv, input bit hb);
    int   tgt;
    int   prev_st;
    exp_t e;
    prev_st = m_st;
    if (m_hb == HB_TIMEOUT)  tgt = 3;
    else if (m_hot == 1)     tgt = 2;
    else if (m_veto == 1)    tgt = 1;
    else                     tgt = 0;
    if (tgt > m_st) begin
      m_st = tgt; m_hold = MIN_HOLD;
    end else if (tgt < m_st) begin
      if (m_hold == 0) begin
        m_st = tgt; m_hold = (tgt == 0) ? 0 : MIN_HOLD;
      end else begin
        m_hold = m_hold - 1;
      end
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
    end
    if (int'(v) != m_veto) begin
      m_dbc = m_dbc + 1;
      if (m_dbc == DEBOUNCE) begin
        m_veto = 1 - m_veto; m_dbc = 0;
      end
    end else begin
      m_dbc = 0;
    end
    if (tv) begin
      if (t >= THERM_HI)      m_hot = 1;
      else if (t <= THERM_LO) m_hot = 0;
    end
    if (hb)                   m_hb = 0;
    else if (m_hb < HB_TIMEOUT) m_hb = m_hb + 1;
    e.status  = 2'(m_st);
    e.changed = (m_st != prev_st);
    e.mask    = {(m_hb == HB_TIMEOUT), m_hot[0], m_veto[0]};
    sb_q.push_back(e);
  endtask

  // One clock: drive at a falling edge, check after the rising edge, and
  // return at the next falling edge.
  task automatic cycle(input bit v, input int t, input bit tv, input bit hb);
    exp_t e;
    bus_if.veto_req     = v;
    bus_if.temp_in      = 8'(t);
    bus_if.temp_valid   = tv;
    bus_if.ai_heartbeat = hb;
    model_step(v, t, tv, hb);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      e = sb_q.pop_front();
      chk("sb_status",  int'(bus_if.status_code_out), int'(e.status));
      chk("sb_changed", int'(bus_if.status_changed),  int'(e.changed));
      chk("sb_mask",    int'(bus_if.cause_mask),      int'(e.mask));
    end
    @(negedge clk);
  endtask

  // Several clocks; when hb_en is set, a heartbeat pulses every 10 cycles.
  task automatic run(input int n, input bit v, input int t, input bit tv, input bit hb_en);
    for (int i = 0; i < n; i++) begin
      cycle(v, t, tv, hb_en && (hb_phase % 10 == 9));
      hb_phase++;
    end
  endtask

  task automatic idle_inputs();
    bus_if.veto_req     = 1'b0;
    bus_if.temp_in      = 8'd0;
    bus_if.temp_valid   = 1'b0;
    bus_if.ai_heartbeat = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    hb_phase = 0;
  endtask

  task automatic chk_out(input string tag, input int st, input int mk);
    $display("%s: status=%0d changed=%0d mask=%b", tag, bus_if.status_code_out,
             bus_if.status_changed, bus_if.cause_mask);
    chk({tag, "_status"}, int'(bus_if.status_code_out), st);
    chk({tag, "_mask"},   int'(bus_if.cause_mask),      mk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    // Checkpoints after each row, with a heartbeat every 10 cycles.
    vecs[0]  = '{1'b0, 8'd50,  1'b1, 5, 2'b00, 3'b000};
    vecs[1]  = '{1'b1, 8'd200, 1'b0, 4, 2'b00, 3'b001}; // veto debounced at 4th edge
    vecs[2]  = '{1'b1, 8'd200, 1'b0, 1, 2'b01, 3'b001}; // status follows one edge later
    vecs[3]  = '{1'b0, 8'd200, 1'b0, 3, 2'b01, 3'b001}; // 3-cycle glitch ignored
    vecs[4]  = '{1'b1, 8'd200, 1'b0, 2, 2'b01, 3'b001};
    vecs[5]  = '{1'b1, 8'd90,  1'b1, 1, 2'b01, 3'b011}; // thermal set
    vecs[6]  = '{1'b1, 8'd200, 1'b0, 1, 2'b10, 3'b011}; // escalate to THERMAL
    vecs[7]  = '{1'b1, 8'd80,  1'b1, 3, 2'b10, 3'b011}; // inside hysteresis band
    vecs[8]  = '{1'b1, 8'd75,  1'b1, 1, 2'b10, 3'b001}; // LO boundary clears
    vecs[9]  = '{1'b1, 8'd200, 1'b0, 4, 2'b10, 3'b001}; // hold still running
    vecs[10] = '{1'b1, 8'd200, 1'b0, 1, 2'b01, 3'b001}; // hold expired -> VETO
    vecs[11] = '{1'b0, 8'd200, 1'b0, 3, 2'b01, 3'b001};
    vecs[12] = '{1'b0, 8'd200, 1'b0, 1, 2'b01, 3'b000}; // veto released
    vecs[13] = '{1'b0, 8'd200, 1'b0, 4, 2'b01, 3'b000};
    vecs[14] = '{1'b0, 8'd200, 1'b0, 1, 2'b00, 3'b000}; // back to OK

    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk_out("reset", 0, 0);
    chk("reset_changed", int'(bus_if.status_changed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int r = 0; r < 15; r++) begin
      run(vecs[r].cycles, vecs[r].veto, int'(vecs[r].temp), vecs[r].tvalid, 1'b1);
      chk_out($sformatf("row%0d", r), int'(vecs[r].exp_status), int'(vecs[r].exp_mask));
    end

    // Watchdog from reset with no heartbeat.
    do_reset();
    run(999, 1'b0, 0, 1'b0, 1'b0);
    chk_out("wd_edge999", 0, 3'b000);
    cycle(1'b0, 0, 1'b0, 1'b0);
    chk_out("wd_edge1000", 0, 3'b100);
    cycle(1'b0, 0, 1'b0, 1'b0);
    chk_out("wd_edge1001", 3, 3'b100);
    chk("wd_changed", int'(bus_if.status_changed), 1);
    cycle(1'b0, 0, 1'b0, 1'b1);                     // heartbeat while saturated
    chk_out("wd_heartbeat", 3, 3'b000);
    run(7, 1'b0, 0, 1'b0, 1'b0);
    chk_out("wd_hold", 3, 3'b000);
    cycle(1'b0, 0, 1'b0, 1'b0);
    chk_out("wd_release", 0, 3'b000);
    chk("wd_release_changed", int'(bus_if.status_changed), 1);

    // Priority and hold: thermal plus veto, thermal clears, AI fault mid-hold.
    do_reset();
    run(992, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 90, 1'b1, 1'b0);
    run(3, 1'b1, 200, 1'b0, 1'b0);
    chk_out("prio_both", 2, 3'b011);
    cycle(1'b1, 70, 1'b1, 1'b0);
    chk_out("prio_thermal_clear", 2, 3'b001);
    run(3, 1'b1, 200, 1'b0, 1'b0);
    chk_out("prio_fault_arrives", 2, 3'b101);
    cycle(1'b1, 200, 1'b0, 1'b0);
    chk_out("prio_escalate", 3, 3'b101);
    chk("prio_changed", int'(bus_if.status_changed), 1);

    // Reset mid-hold: get hold to 5 in AIFAULT, then pulse rst_n mid-cycle.
    cycle(1'b1, 200, 1'b0, 1'b1);
    run(2, 1'b1, 200, 1'b0, 1'b0);
    chk_out("pre_reset", 3, 3'b001);
    #1;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 0, 3'b000);
    chk("async_reset_changed", int'(bus_if.status_changed), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    hb_phase = 0;
    run(6, 1'b0, 0, 1'b0, 1'b1);
    chk_out("post_reset", 0, 3'b000);
    chk("post_reset_changed", int'(bus_if.status_changed), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
